// File: rtl/seg_pkg.sv
// Shared types, scan state encoding and the seven-segment decode table
// used by the display scan controller and its decoder.
package seg_pkg;

    typedef logic [2:0] seg_code_t;
    typedef logic [6:0] seg_pat_t;

    // Index is the digit code; pattern bit order is {g,f,e,d,c,b,a}.
    localparam seg_pat_t SEG_TABLE [8] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07
    };

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-code to segment-pattern lookup.
module seg_decode
    import seg_pkg::*;
(
    input  seg_code_t code,
    output seg_pat_t  pat
);

    assign pat = SEG_TABLE[code];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered digit
// store; new contents are committed only at frame boundaries.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | scan disabled, display dark, digit index parked at 0
//   BLANK | all digits dark for BLANK cycles before the next digit
//   SHOW  | digit cur lit from the live buffer for DWELL cycles
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr_vld,
    output logic                    wr_rdy,
    input  logic [$clog2(NDIG)-1:0] wr_idx,
    input  seg_code_t               wr_data,
    input  logic                    upd,
    output logic [NDIG-1:0]         dig_en,
    output seg_pat_t                segout,
    output logic                    frame_tick
);

    localparam int IDXW    = $clog2(NDIG);
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    scan_state_t     state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] cur_q, cur_d;
    logic            pend_q, pend_d;
    seg_code_t       shadow_q [NDIG];
    seg_code_t       shadow_d [NDIG];
    seg_code_t       live_q   [NDIG];
    seg_code_t       live_d   [NDIG];

    logic            wr_rdy_q, wr_rdy_d;
    logic [NDIG-1:0] dig_en_q, dig_en_d;
    seg_pat_t        segout_q, segout_d;
    logic            frame_tick_q, frame_tick_d;

    seg_pat_t        seg_live;
    logic            wr_take;

    seg_decode u_decode (
        .code (live_q[cur_q]),
        .pat  (seg_live)
    );

    assign wr_take = wr_vld && wr_rdy_q && (int'(wr_idx) < NDIG);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        pend_d       = pend_q;
        shadow_d     = shadow_q;
        live_d       = live_q;
        frame_tick_d = 1'b0;

        if (wr_take) begin
            shadow_d[wr_idx] = wr_data;
        end
        if (upd && !pend_q) begin
            pend_d = 1'b1;
        end

        if (!en) begin
            state_d = seg_pkg::IDLE;
            cnt_d   = '0;
            cur_d   = '0;
        end else begin
            unique case (state_q)
                seg_pkg::IDLE: begin
                    state_d = seg_pkg::BLANK;
                    cnt_d   = '0;
                    cur_d   = '0;
                end
                seg_pkg::BLANK: begin
                    if (cnt_q == CNTW'(BLANK - 1)) begin
                        state_d = seg_pkg::SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                seg_pkg::SHOW: begin
                    if (cnt_q == CNTW'(DWELL - 1)) begin
                        state_d = seg_pkg::BLANK;
                        cnt_d   = '0;
                        if (cur_q == IDXW'(NDIG - 1)) begin
                            // Frame boundary: pending writes cannot be accepted
                            // while pend is set, so shadow_q is the final image.
                            cur_d        = '0;
                            frame_tick_d = 1'b1;
                            if (pend_q) begin
                                live_d = shadow_q;
                                pend_d = 1'b0;
                            end
                        end else begin
                            cur_d = cur_q + IDXW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                default: begin
                    state_d = seg_pkg::IDLE;
                    cnt_d   = '0;
                    cur_d   = '0;
                end
            endcase
        end

        // cur only moves on leaving SHOW, so cur_q/live_q already point at the
        // digit that is about to be lit when the next state is SHOW.
        wr_rdy_d = !pend_d;
        if (state_d == seg_pkg::SHOW) begin
            dig_en_d = NDIG'(1) << cur_d;
            segout_d = seg_live;
        end else begin
            dig_en_d = '0;
            segout_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= seg_pkg::IDLE;
            cnt_q        <= '0;
            cur_q        <= '0;
            pend_q       <= 1'b0;
            shadow_q     <= '{default: '0};
            live_q       <= '{default: '0};
            wr_rdy_q     <= 1'b1;
            dig_en_q     <= '0;
            segout_q     <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            shadow_q     <= shadow_d;
            live_q       <= live_d;
            wr_rdy_q     <= wr_rdy_d;
            dig_en_q     <= dig_en_d;
            segout_q     <= segout_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign wr_rdy     = wr_rdy_q;
    assign dig_en     = dig_en_q;
    assign segout     = segout_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: time-based reference model plus
// directed scenarios and a randomized soak.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int PER   = BL + DW;
    localparam int FRAME = ND * PER;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_vld;
    logic       wr_rdy;
    logic [1:0] wr_idx;
    logic [2:0] wr_data;
    logic       upd;
    logic [3:0] dig_en;
    logic [6:0] segout;
    logic       frame_tick;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    seg_scan_ctrl #(.NDIG(ND), .DWELL(DW), .BLANK(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_vld     (wr_vld),
        .wr_rdy     (wr_rdy),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .upd        (upd),
        .dig_en     (dig_en),
        .segout     (segout),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [2:0] c);
        case (c)
            3'd0: ref_seg = 7'h3F;
            3'd1: ref_seg = 7'h06;
            3'd2: ref_seg = 7'h5B;
            3'd3: ref_seg = 7'h4F;
            3'd4: ref_seg = 7'h66;
            3'd5: ref_seg = 7'h6D;
            3'd6: ref_seg = 7'h7D;
            default: ref_seg = 7'h07;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: scan position is pure arithmetic on the number of
    // cycles since scanning started.
    logic [2:0] m_shadow [ND] = '{default: 3'd0};
    logic [2:0] m_live   [ND] = '{default: 3'd0};
    logic       m_pend = 1'b0;
    logic       m_run  = 1'b0;
    int         m_t    = 0;
    logic [3:0] m_dig  = 4'd0;
    logic [6:0] m_seg  = 7'd0;
    logic       m_tick = 1'b0;
    logic       m_rdy  = 1'b1;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_shadow = '{default: 3'd0};
                m_live   = '{default: 3'd0};
                m_pend   = 1'b0;
                m_run    = 1'b0;
                m_t      = 0;
                m_dig    = 4'd0;
                m_seg    = 7'd0;
                m_tick   = 1'b0;
                m_rdy    = 1'b1;
            end else begin
                logic old_pend;
                cyc++;
                old_pend = m_pend;
                if (wr_vld && !old_pend && int'(wr_idx) < ND) m_shadow[wr_idx] = wr_data;
                m_tick = 1'b0;
                if (!en) begin
                    m_run = 1'b0;
                end else if (!m_run) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end else begin
                    m_t++;
                    if (m_t % FRAME == 0) begin
                        m_tick = 1'b1;
                        if (old_pend) m_live = m_shadow;
                    end
                end
                m_pend = old_pend ? !m_tick : upd;
                m_rdy  = !m_pend;
                m_dig  = 4'd0;
                m_seg  = 7'd0;
                if (m_run && (m_t % PER) >= BL) begin
                    int d;
                    d     = (m_t / PER) % ND;
                    m_dig = 4'd1 << d;
                    m_seg = ref_seg(m_live[d]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_dig_en", 32'(dig_en), 32'(m_dig));
            chk("model_segout", 32'(segout), 32'(m_seg));
            chk("model_frame_tick", 32'(frame_tick), 32'(m_tick));
            chk("model_wr_rdy", 32'(wr_rdy), 32'(m_rdy));
        end
    end

    task automatic wait_dig(input logic [3:0] m, input string nm);
        int n = 0;
        while (dig_en !== m && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (dig_en !== m) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout, dig_en=%b expected %b", nm, dig_en, m);
        end
    endtask

    task automatic wait_tick(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        if (frame_tick !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout, frame_tick=%b expected 1", nm, frame_tick);
        end
    endtask

    initial begin
        logic [6:0] exp_pat [4];
        int c0;
        int n;
        exp_pat = '{7'h06, 7'h5B, 7'h4F, 7'h07};
        rst = 1'b1; en = 1'b0; wr_vld = 1'b0; wr_idx = 2'd0; wr_data = 3'd0; upd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dig_en", 32'(dig_en), 32'd0);
        chk("rst_segout", 32'(segout), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // First enable: two dark cycles then digit 0 with code 0.
        en = 1'b1;
        @(negedge clk); chk("blank0", 32'(dig_en), 32'd0);
        @(negedge clk); chk("blank1", 32'(dig_en), 32'd0);
        @(negedge clk); chk("dig0_on", 32'(dig_en), 32'd1);
        chk("dig0_seg", 32'(segout), 32'h3F);
        wait_tick("tick_first");
        c0 = cyc;
        wait_tick("tick_second");
        chk("tick_period", 32'(cyc - c0), 32'd24);

        // Fill shadow, request commit mid-frame.
        for (int i = 0; i < 4; i++) begin
            wr_vld = 1'b1; wr_idx = 2'(i); wr_data = exp_pat[i] == 7'h07 ? 3'd7 : 3'(i + 1);
            @(negedge clk);
        end
        wr_vld = 1'b0;
        wait_dig(4'b0010, "mid_frame");
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        chk("rdy_pend", 32'(wr_rdy), 32'd0);
        n = 0;
        while (frame_tick !== 1'b1 && n < 100) begin
            if (dig_en != 4'd0) chk("old_frame_seg", 32'(segout), 32'h3F);
            chk("rdy_hold", 32'(wr_rdy), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("commit_tick", 32'(frame_tick), 32'd1);
        chk("rdy_back", 32'(wr_rdy), 32'd1);
        for (int d = 0; d < 4; d++) begin
            wait_dig(4'(1 << d), "new_frame");
            chk("new_frame_seg", 32'(segout), 32'(exp_pat[d]));
        end

        // Write and commit request in the same cycle.
        wr_vld = 1'b1; wr_idx = 2'd2; wr_data = 3'd5; upd = 1'b1;
        @(negedge clk);
        wr_vld = 1'b0; upd = 1'b0;
        chk("both_pend", 32'(wr_rdy), 32'd0);
        wait_tick("both_tick");
        wait_dig(4'b0100, "both_dig2");
        chk("both_seg", 32'(segout), 32'h6D);

        // Write held while pending is stalled until the commit clears.
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        wr_vld = 1'b1; wr_idx = 2'd0; wr_data = 3'd4;
        n = 0;
        while (wr_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held_rdy_at_tick", 32'(frame_tick), 32'd1);
        @(negedge clk);
        wr_vld = 1'b0;
        wait_dig(4'b0001, "held_dig0");
        chk("held_not_live", 32'(segout), 32'h06);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        wait_tick("held_tick");
        wait_dig(4'b0001, "held_dig0b");
        chk("held_live", 32'(segout), 32'h66);

        // Drop enable while digit 1 is lit.
        wait_dig(4'b0010, "en_drop");
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_dig", 32'(dig_en), 32'd0);
        chk("en_drop_seg", 32'(segout), 32'd0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk); chk("re_blank0", 32'(dig_en), 32'd0);
        @(negedge clk); chk("re_blank1", 32'(dig_en), 32'd0);
        @(negedge clk); chk("re_dig0", 32'(dig_en), 32'd1);

        // Asynchronous reset mid-SHOW.
        wait_dig(4'b0010, "rst_mid");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dig", 32'(dig_en), 32'd0);
        chk("async_rst_seg", 32'(segout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            wait_dig(4'(1 << d), "rst_restart");
            chk("rst_live_seg", 32'(segout), 32'h3F);
        end

        // Randomized soak against the model.
        for (int k = 0; k < 1500; k++) begin
            en      = ($urandom_range(0, 199) != 0);
            wr_vld  = 1'($urandom_range(0, 1));
            wr_idx  = 2'($urandom_range(0, 3));
            wr_data = 3'($urandom_range(0, 7));
            upd     = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end
        en = 1'b0; wr_vld = 1'b0; upd = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for a multi-digit seven-segment display built on the segment datapath (3-bit digit code in, 7-bit segment pattern out). Holds a double-buffered digit register file written through a valid/ready port. Rotates a one-hot digit enable with a blanking gap between digits to suppress ghosting. Commits new display contents only at frame boundaries so a frame never shows a mix of old and new digits.

## Interface
- NDIG, 4: number of digits scanned; must be at least 2.
- DWELL, 1000: clk cycles each digit is lit; must be at least 1.
- BLANK, 16: clk cycles all digits are dark before each digit is lit; must be at least 1.
- clk  input  1  the single clock; all logic is on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; 0 forces the display dark.
- wr_vld  input  1  write request.
- wr_rdy  output  1  write may be accepted.
- wr_idx  input  $clog2(NDIG)  digit index to write; values of NDIG or more are dropped.
- wr_data  input  3  digit code, 0–7.
- upd  input  1  request to commit the shadow buffer at the next frame boundary.
- dig_en  output  NDIG  one-hot digit enable, active-high.
- segout  output  7  segment pattern {g,f,e,d,c,b,a}, active-high.
- frame_tick  output  1  one-cycle pulse at each frame boundary.

## Operation
- Storage:
  - shadow[NDIG] holds 3-bit codes and is written by the port.
  - live[NDIG] holds 3-bit codes and is the only buffer displayed.
- Write port:
  - A write is accepted when wr_vld && wr_rdy; it sets shadow[wr_idx] = wr_data.
  - wr_rdy = !pend.
- Commit request:
  - upd sets pend when pend = 0.
  - upd while pend = 1 is ignored.
  - A write and upd in the same cycle are both taken, and the commit includes that write.
- FSM states IDLE, BLANK, SHOW; cnt is the phase counter and cur is the digit index.
  - IDLE: dig_en = 0, segout = 0, cur = 0. Goes to BLANK when en = 1, with cnt = 0.
  - BLANK: dig_en = 0, segout = 0. Goes to SHOW after BLANK cycles.
  - SHOW: dig_en = 1 << cur, segout = decode(live[cur]). After DWELL cycles, go to BLANK and advance cur.
  - cur wraps from NDIG-1 to 0. That transition is the frame boundary:
    - pulse frame_tick;
    - if pend, copy shadow to live and clear pend.
  - en = 0 in any state goes to IDLE on the next edge and drops the current frame. pend is retained.
- Decode table, code to segout:
  - 0→7'h3F, 1→7'h06, 2→7'h5B, 3→7'h4F
  - 4→7'h66, 5→7'h6D, 6→7'h7D, 7→7'h07

## Timing
- Reset values:
  - dig_en = 0, segout = 0, frame_tick = 0, wr_rdy = 1.
  - shadow, live, pend, cur and cnt are all 0; state is IDLE.
- All outputs are registered.
- en sampled high at edge N gives BLANK from N+1. Digit 0 is lit from N+1+BLANK.
- Digit period = BLANK + DWELL cycles. Frame period = NDIG × (BLANK + DWELL) cycles.
- frame_tick is high for the first BLANK cycle after digit NDIG-1 goes dark.
- A commit takes effect from that same cycle, so the next lit digit 0 shows the new data.
- wr_rdy returns to 1 in the cycle after the commit edge.
- A write to shadow never changes segout until a commit.
- A write to the index currently displayed has no visible effect before the commit.
- rst asserted mid-scan clears all outputs immediately, without waiting for a clock edge.
- Scanning restarts from digit 0 with a full BLANK phase after rst deasserts, provided en = 1.

## Structure
- Package seg_pkg holds:
  - typedef seg_code_t (logic [2:0]) and typedef seg_pat_t (logic [6:0]);
  - the 8-entry decode constant array;
  - enum scan_state_t {IDLE, BLANK, SHOW}.
- Sub-module seg_decode is purely combinational, seg_code_t to seg_pat_t, and reads the package table. It is instantiated once, on live[cur].
- The top level holds the FSM, counters, both buffers and the handshake.

## Test plan
Use NDIG = 4, DWELL = 4, BLANK = 2 throughout.
- Reset, then en = 1 with no writes:
  - digits 0..3 are each lit for 4 cycles with segout = 7'h3F;
  - every lit digit is preceded by 2 dark cycles;
  - frame_tick repeats every 24 cycles.
- Write codes 1, 2, 3, 7 to indices 0–3, then pulse upd mid-frame:
  - the current frame keeps showing 7'h3F;
  - wr_rdy stays 0 until the boundary;
  - the next frame shows 7'h06, 7'h5B, 7'h4F, 7'h07.
- Same cycle wr_vld && upd with idx 2, data 5: accepted; the next frame shows digit 2 = 7'h6D.
- wr_vld held during pend: not accepted until wr_rdy = 1; the data lands in shadow only after that.
- Drop en mid-SHOW of digit 1:
  - dig_en = 0 and segout = 0 from the next cycle;
  - on re-enable, scanning restarts at digit 0 after 2 blank cycles.
- Assert rst asynchronously mid-SHOW:
  - outputs are 0 before the next edge;
  - live is cleared, so the restart shows 7'h3F on all digits.
